phased_clock_bank: RTL and testbench

- Multi-channel successor to the single-channel transducer clock divider.
- Generates CHANNELS square waves that share one half-period count. Each channel has its own programmable phase offset, sign (initial level) and output enable.
- All new settings are double-buffered: writes land in shadow registers and are applied to every channel together, only on a master period boundary. Phase patterns therefore change without glitches or inter-channel skew.
- Sits between the host command decoder (write port) and the transducer drivers (out bus).

---
 rtl/phased_clock_bank_if.sv | 18 +
 rtl/phased_clock_bank.sv | 123 ++++++++++++
 tb/tb_phased_clock_bank.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phased_clock_bank_if.sv
// Host write/commit port and transducer output bus of phased_clock_bank.
// The host drives the master side; the clock bank implements the slave side.
interface phased_clock_bank_if #(
   parameter int CHANNELS   = 8,
   parameter int CNT_WIDTH  = 10,
   parameter int ADDR_WIDTH = 4
);
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [CNT_WIDTH+1:0]  wr_data;
   logic                  commit;
   logic                  busy;
   logic                  sync;
   logic [CHANNELS-1:0]   out;

   modport master (output wr_en, wr_addr, wr_data, commit, input busy, sync, out);
   modport slave  (input wr_en, wr_addr, wr_data, commit, output busy, sync, out);
endinterface

// File: rtl/phased_clock_bank.sv
// Multi-channel square-wave generator sharing one half-period count, with
// double-buffered per-channel phase/sign/enable applied together at period end.
module phased_clock_bank #(
   parameter int CHANNELS       = 8,
   parameter int CNT_WIDTH      = 10,
   parameter int ADDR_WIDTH     = 4,
   parameter int DEFAULT_DIVIDE = 624
) (
   input  logic               clk,
   input  logic               rst,
   phased_clock_bank_if.slave bus
);
   typedef logic [CNT_WIDTH-1:0] cnt_t;

   // Field order matches the channel write-data layout, so a write is a plain cast.
   typedef struct packed {
      logic oe;
      logic sign;
      cnt_t offset;
   } ch_cfg_t;

   localparam cnt_t                  DIVIDE_RST = cnt_t'(DEFAULT_DIVIDE);
   localparam logic [ADDR_WIDTH-1:0] DIV_ADDR   = ADDR_WIDTH'(CHANNELS);

   cnt_t                cnt_q, cnt_d;
   logic                mh_q, mh_d;
   cnt_t                div_act_q, div_act_d;
   cnt_t                div_sh_q, div_sh_d;
   ch_cfg_t             sh_q [CHANNELS];
   ch_cfg_t             sh_d [CHANNELS];
   logic [CHANNELS-1:0] oe_act_q, oe_act_d;
   cnt_t                ch_cnt_q [CHANNELS];
   cnt_t                ch_cnt_d [CHANNELS];
   logic [CHANNELS-1:0] ch_lvl_q, ch_lvl_d;
   logic                pending_q, pending_d;
   logic                sync_q, sync_d;
   logic                period_end;
   logic                apply;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      cnt_d     = cnt_q + 1'b1;
      mh_d      = mh_q;
      div_act_d = div_act_q;
      div_sh_d  = div_sh_q;
      sh_d      = sh_q;
      oe_act_d  = oe_act_q;
      ch_cnt_d  = ch_cnt_q;
      ch_lvl_d  = ch_lvl_q;

      period_end = (cnt_q == div_act_q) && mh_q;
      apply      = period_end && pending_q;

      if (apply) begin
         cnt_d     = '0;
         mh_d      = 1'b0;
         div_act_d = div_sh_q;
      end else if (cnt_q == div_act_q) begin
         cnt_d = '0;
         mh_d  = ~mh_q;
      end

      // A commit coinciding with an apply re-arms for the next period end.
      pending_d = apply ? bus.commit : (pending_q | bus.commit);
      sync_d    = apply;

      if (bus.wr_en && (bus.wr_addr == DIV_ADDR)) begin
         div_sh_d = bus.wr_data[CNT_WIDTH-1:0];
      end

      for (int i = 0; i < CHANNELS; i++) begin
         if (bus.wr_en && (bus.wr_addr == ADDR_WIDTH'(i))) begin
            sh_d[i] = ch_cfg_t'(bus.wr_data);
         end
         // Apply reads the pre-write shadows, so a same-cycle write waits for the next commit.
         if (apply) begin
            ch_cnt_d[i] = (sh_q[i].offset > div_sh_q) ? div_sh_q : sh_q[i].offset;
            ch_lvl_d[i] = sh_q[i].sign;
            oe_act_d[i] = sh_q[i].oe;
         end else if (ch_cnt_q[i] == div_act_q) begin
            ch_cnt_d[i] = '0;
            ch_lvl_d[i] = ~ch_lvl_q[i];
         end else begin
            ch_cnt_d[i] = ch_cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state updates use <= so every register samples the pre-edge values.
      if (!rst) begin
         cnt_q     <= '0;
         mh_q      <= 1'b0;
         div_act_q <= DIVIDE_RST;
         div_sh_q  <= DIVIDE_RST;
         oe_act_q  <= '0;
         ch_lvl_q  <= '0;
         pending_q <= 1'b0;
         sync_q    <= 1'b0;
         // NOTE: the register arrays are reset explicitly; shadows must read as zero after reset.
         for (int i = 0; i < CHANNELS; i++) begin
            sh_q[i]     <= '0;
            ch_cnt_q[i] <= '0;
         end
      end else begin
         cnt_q     <= cnt_d;
         mh_q      <= mh_d;
         div_act_q <= div_act_d;
         div_sh_q  <= div_sh_d;
         sh_q      <= sh_d;
         oe_act_q  <= oe_act_d;
         ch_cnt_q  <= ch_cnt_d;
         ch_lvl_q  <= ch_lvl_d;
         pending_q <= pending_d;
         sync_q    <= sync_d;
      end
   end

   assign bus.out  = ch_lvl_q & oe_act_q;
   assign bus.busy = pending_q;
   assign bus.sync = sync_q;

endmodule

// File: tb/tb_phased_clock_bank.sv
// Self-checking bench for phased_clock_bank: closed-form scoreboard model checked
// every cycle, plus a vector table and hand-written corner-case sequences.
module tb_phased_clock_bank;
   localparam int CH  = 4;
   localparam int CW  = 4;
   localparam int AW  = 3;
   localparam int DEF = 15;

   typedef struct packed {
      logic          oe;
      logic          sign;
      logic [CW-1:0] off;
   } cfg_t;

   typedef struct packed {
      logic          busy;
      logic          sync;
      logic [CH-1:0] out;
   } exp_t;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [CW+1:0] data;
      logic          cm;
      logic [CH-1:0] exp_out;
      logic          exp_sync;
      logic          exp_busy;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   exp_t sb_q [$];

   phased_clock_bank_if #(.CHANNELS(CH), .CNT_WIDTH(CW), .ADDR_WIDTH(AW)) bus ();

   phased_clock_bank #(
      .CHANNELS      (CH),
      .CNT_WIDTH     (CW),
      .ADDR_WIDTH    (AW),
      .DEFAULT_DIVIDE(DEF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: time since the last apply (or reset) gives every output in closed form.
   int   m_t;
   int   m_div_act;
   int   m_div_sh;
   cfg_t m_sh [CH];
   int   m_off [CH];
   bit   m_sign [CH];
   bit   m_oe [CH];
   bit   m_pend;
   bit   m_sync;
   bit   m_applied;

   function automatic exp_t model_out();
      exp_t e;
      e.busy = m_pend;
      e.sync = m_sync;
      e.out  = '0;
      for (int i = 0; i < CH; i++) begin
         if (m_applied && m_oe[i]) begin
            e.out[i] = m_sign[i] ^ ((((m_t + m_off[i]) / (m_div_act + 1)) % 2) != 0);
         end
      end
      return e;
   endfunction

   always @(posedge clk) begin : model
      bit ap;
      int per;
      if (!rst) begin
         m_t       = 0;
         m_div_act = DEF;
         m_div_sh  = DEF;
         m_pend    = 1'b0;
         m_sync    = 1'b0;
         m_applied = 1'b0;
         for (int i = 0; i < CH; i++) begin
            m_sh[i]   = '0;
            m_off[i]  = 0;
            m_sign[i] = 1'b0;
            m_oe[i]   = 1'b0;
         end
      end else begin
         per = 2 * (m_div_act + 1);
         ap  = m_pend && ((m_t % per) == per - 1);
         if (ap) begin
            for (int i = 0; i < CH; i++) begin
               m_off[i]  = (int'(m_sh[i].off) > m_div_sh) ? m_div_sh : int'(m_sh[i].off);
               m_sign[i] = m_sh[i].sign;
               m_oe[i]   = m_sh[i].oe;
            end
            m_div_act = m_div_sh;
            m_t       = 0;
            m_applied = 1'b1;
         end else begin
            m_t++;
         end
         m_pend = ap ? bus.commit : (m_pend | bus.commit);
         m_sync = ap;
         if (bus.wr_en) begin
            if (int'(bus.wr_addr) < CH) m_sh[int'(bus.wr_addr)] = cfg_t'(bus.wr_data);
            else if (int'(bus.wr_addr) == CH) m_div_sh = int'(bus.wr_data[CW-1:0]);
         end
      end
      sb_q.push_back(model_out());
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_busy", 32'(bus.busy), 32'(e.busy));
            check("sb_sync", 32'(bus.sync), 32'(e.sync));
            check("sb_out",  32'(bus.out),  32'(e.out));
         end
      end
   end

   // Inputs change just after a falling edge and are sampled at the following rising edge.
   task automatic cycle(input logic we, input logic [AW-1:0] a, input logic [CW+1:0] d, input logic cm);
      bus.wr_en   = we;
      bus.wr_addr = a;
      bus.wr_data = d;
      bus.commit  = cm;
      @(negedge clk);
      bus.wr_en  = 1'b0;
      bus.commit = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, '0, '0, 1'b0);
   endtask

   task automatic wait_sync(input string name, input int max_cycles);
      int n;
      n = 0;
      while (bus.sync !== 1'b1 && n < max_cycles) begin
         idle(1);
         n++;
      end
      check(name, 32'(bus.sync), 32'd1);
   endtask

   initial begin : stimulus
      vec_t          vecs [16];
      logic [CH-1:0] pat [8];
      int            seen;

      // One period of the divide=3 pattern, out = {ch3, ch2, ch1, ch0}.
      pat = '{4'b0100, 4'b0100, 4'b0110, 4'b0110, 4'b0011, 4'b0011, 4'b0001, 4'b0001};
      for (int k = 0; k < 16; k++) begin
         vecs[k] = '{we: 1'b0, addr: '0, data: '0, cm: 1'b0,
                     exp_out: pat[k % 8], exp_sync: (k == 0), exp_busy: 1'b0};
      end
      vecs[3].we   = 1'b1;
      vecs[3].addr = 3'd1;
      vecs[3].data = 6'h21;

      checks      = 0;
      failures    = 0;
      rst         = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.commit  = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_sync", 32'(bus.sync), 32'd0);
      check("rst_out",  32'(bus.out),  32'd0);
      rst = 1'b1;

      idle(700);
      check("idle_out",  32'(bus.out),  32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);

      // Phase pattern, including an ignored out-of-range address.
      cycle(1'b1, 3'd4, 6'h03, 1'b0);
      cycle(1'b1, 3'd0, 6'h20, 1'b0);
      cycle(1'b1, 3'd1, 6'h22, 1'b0);
      cycle(1'b1, 3'd2, 6'h30, 1'b0);
      cycle(1'b1, 3'd3, 6'h00, 1'b0);
      cycle(1'b1, 3'd7, 6'h3F, 1'b0);
      cycle(1'b0, 3'd0, 6'h00, 1'b1);
      check("busy_after_commit", 32'(bus.busy), 32'd1);
      wait_sync("sync_first_apply", 100);

      for (int k = 0; k < 16; k++) begin
         check($sformatf("vec%0d_out", k),  32'(bus.out),  32'(vecs[k].exp_out));
         check($sformatf("vec%0d_sync", k), 32'(bus.sync), 32'(vecs[k].exp_sync));
         check($sformatf("vec%0d_busy", k), 32'(bus.busy), 32'(vecs[k].exp_busy));
         cycle(vecs[k].we, vecs[k].addr, vecs[k].data, vecs[k].cm);
      end

      // Uncommitted ch1 offset change leaves the running pattern alone (now at t=16).
      idle(24);
      check("hold_out", 32'(bus.out), 32'(4'b0100));

      cycle(1'b0, 3'd0, 6'h00, 1'b1);
      wait_sync("sync_offset1", 20);
      check("off1_t0", 32'(bus.out[1]), 32'd0);
      idle(2);
      check("off1_t2", 32'(bus.out[1]), 32'd0);
      idle(1);
      check("off1_t3", 32'(bus.out[1]), 32'd1);

      // Offset 9 clamps to divide 3.
      cycle(1'b1, 3'd0, 6'h29, 1'b0);
      cycle(1'b0, 3'd0, 6'h00, 1'b1);
      wait_sync("sync_clamp", 20);
      check("clamp_t0", 32'(bus.out[0]), 32'd0);
      idle(1);
      check("clamp_t1", 32'(bus.out[0]), 32'd1);
      idle(3);
      check("clamp_t4", 32'(bus.out[0]), 32'd1);
      idle(1);
      check("clamp_t5", 32'(bus.out[0]), 32'd0);

      // Commit in a period-end cycle with nothing pending waits a full period.
      idle(2);
      cycle(1'b0, 3'd0, 6'h00, 1'b1);
      check("pe_commit_no_sync", 32'(bus.sync), 32'd0);
      check("pe_commit_busy",    32'(bus.busy), 32'd1);
      idle(7);
      check("pe_commit_t15", 32'(bus.sync), 32'd0);
      idle(1);
      check("pe_commit_t16", 32'(bus.sync), 32'd1);

      // Write and commit in the exact apply cycle.
      cycle(1'b0, 3'd0, 6'h00, 1'b1);
      idle(6);
      cycle(1'b1, 3'd0, 6'h30, 1'b1);
      check("same_cyc_sync", 32'(bus.sync),   32'd1);
      check("same_cyc_busy", 32'(bus.busy),   32'd1);
      check("same_cyc_old",  32'(bus.out[0]), 32'd0);
      idle(7);
      check("rearm_t7_sync", 32'(bus.sync), 32'd0);
      idle(1);
      check("rearm_t8_sync", 32'(bus.sync),   32'd1);
      check("rearm_t8_busy", 32'(bus.busy),   32'd0);
      check("rearm_t8_new",  32'(bus.out[0]), 32'd1);

      // Divide 0: every channel toggles each cycle, offsets clamp to 0.
      cycle(1'b1, 3'd4, 6'h00, 1'b0);
      cycle(1'b1, 3'd0, 6'h25, 1'b0);
      cycle(1'b1, 3'd1, 6'h30, 1'b0);
      cycle(1'b0, 3'd0, 6'h00, 1'b1);
      wait_sync("sync_div0", 20);
      check("div0_t0", 32'(bus.out), 32'(4'b0110));
      idle(1);
      check("div0_t1", 32'(bus.out), 32'(4'b0001));
      idle(1);
      check("div0_t2", 32'(bus.out), 32'(4'b0110));

      // Reset while a commit is pending, with a write in the reset cycle.
      cycle(1'b1, 3'd4, 6'h03, 1'b0);
      cycle(1'b0, 3'd0, 6'h00, 1'b1);
      wait_sync("sync_div3", 20);
      cycle(1'b0, 3'd0, 6'h00, 1'b1);
      idle(1);
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      rst = 1'b0;
      cycle(1'b1, 3'd0, 6'h3F, 1'b0);
      cycle(1'b0, 3'd0, 6'h00, 1'b0);
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      check("mid_rst_out",  32'(bus.out),  32'd0);
      rst  = 1'b1;
      seen = 0;
      repeat (40) begin
         idle(1);
         if (bus.sync === 1'b1) seen++;
      end
      check("no_sync_after_rst", 32'(seen), 32'd0);
      cycle(1'b0, 3'd0, 6'h00, 1'b1);
      wait_sync("sync_after_rst", 100);
      check("rst_shadow_out", 32'(bus.out), 32'd0);
      idle(20);
      check("rst_shadow_out2", 32'(bus.out), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
